// File: rtl/exu_cal_mc_if.sv
// Request/result handshake bundle between the EX stage and the multi-cycle calculation unit.
// master = EX side, slave = calculation unit.
interface exu_cal_mc_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic              hs_ex4cal_val;
  logic              hs_cal4ex_rdy;
  logic [3:0]        i_op;
  logic [XLEN-1:0]   i_opn1;
  logic [XLEN-1:0]   i_opn2;
  logic [TAG_W-1:0]  i_tag;
  logic              hs_cal4ex_res_val;
  logic              hs_ex4cal_res_rdy;
  logic [XLEN-1:0]   o_res;
  logic [TAG_W-1:0]  o_tag;
  logic              o_ill;

  modport master (
    output hs_ex4cal_val, i_op, i_opn1, i_opn2, i_tag, hs_ex4cal_res_rdy,
    input  hs_cal4ex_rdy, hs_cal4ex_res_val, o_res, o_tag, o_ill
  );

  modport slave (
    input  hs_ex4cal_val, i_op, i_opn1, i_opn2, i_tag, hs_ex4cal_res_rdy,
    output hs_cal4ex_rdy, hs_cal4ex_res_val, o_res, o_tag, o_ill
  );
endinterface

// File: rtl/exu_cal_mc.sv
// Multi-cycle integer calculation unit: single-cycle ALU ops plus an iterative shifter.
// Define CIRNO_CAL_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
//
// state | meaning
// IDLE  | no operation held, ready for a request
// SHIFT | iterative shift in progress, request side stalled
// DONE  | result presented, waiting for the result handshake
module exu_cal_mc #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int TAG_W      = 4
) (
  input  logic         clk,
  input  logic         rst,
  exu_cal_mc_if.slave  cal
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic              res_val;
  logic [XLEN-1:0]   res;
  logic [TAG_W-1:0]  tag;
  logic              ill;

  logic              rdy;
  logic              accept;
  logic              is_ill;
  logic              cmp_signed;
  logic [SHW-1:0]    amt;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   alu_res;

  assign rdy    = (state == IDLE) | ((state == DONE) & cal.hs_ex4cal_res_rdy);
  assign accept = cal.hs_ex4cal_val & rdy;

  assign cal.hs_cal4ex_rdy     = rdy;
  assign cal.hs_cal4ex_res_val = res_val;
  assign cal.o_res             = res;
  assign cal.o_tag             = tag;
  assign cal.o_ill             = ill;

  // One XLEN+1 subtract serves SUB, SLT and SLTU; the extension bit selects signedness.
  always_comb begin
    cmp_signed = (cal.i_op == OP_SLT);
    diff       = {cmp_signed & cal.i_opn1[XLEN-1], cal.i_opn1}
               - {cmp_signed & cal.i_opn2[XLEN-1], cal.i_opn2};
    amt        = cal.i_opn2[SHW-1:0];
    is_ill     = (cal.i_op > OP_SLTU);
    alu_res    = '0;
    case (cal.i_op)
      OP_ADD:  alu_res = cal.i_opn1 + cal.i_opn2;
      OP_SUB:  alu_res = diff[XLEN-1:0];
`ifdef CIRNO_CAL_BARREL_SHIFT_EN
      OP_SLL:  alu_res = cal.i_opn1 << amt;
      OP_SRL:  alu_res = cal.i_opn1 >> amt;
      OP_SRA:  alu_res = $signed(cal.i_opn1) >>> amt;
`else
      // Only reached with a zero shift amount; non-zero amounts go through SHIFT.
      OP_SLL, OP_SRL, OP_SRA: alu_res = cal.i_opn1;
`endif
      OP_XOR:  alu_res = cal.i_opn1 ^ cal.i_opn2;
      OP_OR:   alu_res = cal.i_opn1 | cal.i_opn2;
      OP_AND:  alu_res = cal.i_opn1 & cal.i_opn2;
      OP_SLT, OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, diff[XLEN]};
      default: alu_res = '0;
    endcase
  end

`ifndef CIRNO_CAL_BARREL_SHIFT_EN
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  logic [XLEN-1:0]   sh_val;
  logic [XLEN-1:0]   sh_next;
  logic [SHW:0]      sh_rem;
  logic [SHW:0]      sh_step;
  logic [SHW:0]      rem_next;
  logic              sh_left;
  logic              sh_arith;
  logic              is_shift;

  always_comb begin
    is_shift = (cal.i_op == OP_SLL) | (cal.i_op == OP_SRL) | (cal.i_op == OP_SRA);
    sh_step  = (sh_rem < STEP) ? sh_rem : STEP;
    rem_next = sh_rem - sh_step;
    if (sh_left)
      sh_next = sh_val << sh_step;
    else if (sh_arith)
      sh_next = $signed(sh_val) >>> sh_step;
    else
      sh_next = sh_val >> sh_step;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      res_val <= 1'b0;
      res     <= '0;
      tag     <= '0;
      ill     <= 1'b0;
`ifndef CIRNO_CAL_BARREL_SHIFT_EN
      sh_val   <= '0;
      sh_rem   <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            tag <= cal.i_tag;
            ill <= is_ill;
`ifndef CIRNO_CAL_BARREL_SHIFT_EN
            if (is_shift && (amt != '0)) begin
              state    <= SHIFT;
              res_val  <= 1'b0;
              sh_val   <= cal.i_opn1;
              sh_rem   <= {1'b0, amt};
              sh_left  <= (cal.i_op == OP_SLL);
              sh_arith <= (cal.i_op == OP_SRA);
            end else begin
              state   <= DONE;
              res_val <= 1'b1;
              res     <= alu_res;
            end
`else
            state   <= DONE;
            res_val <= 1'b1;
            res     <= alu_res;
`endif
          end else if ((state == DONE) && cal.hs_ex4cal_res_rdy) begin
            state   <= IDLE;
            res_val <= 1'b0;
          end
        end
`ifndef CIRNO_CAL_BARREL_SHIFT_EN
        SHIFT: begin
          sh_val <= sh_next;
          sh_rem <= rem_next;
          if (rem_next == '0) begin
            state   <= DONE;
            res_val <= 1'b1;
            res     <= sh_next;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          res_val <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exu_cal_mc.sv
// Self-checking bench for exu_cal_mc: directed vectors with literal expectations plus a
// queue-based reference model compared against the result port every cycle.
module tb_exu_cal_mc;
  localparam int XLEN  = 32;
  localparam int STEP  = 1;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exu_cal_mc_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  exu_cal_mc #(.XLEN(XLEN), .SHIFT_STEP(STEP), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .cal (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        ill;
    int          due;
  } exp_t;

  exp_t q[$];
  bit   just_rst = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return a >> sh;
      4'd4: return $signed(a) >>> sh;
      4'd5: return a ^ b;
      4'd6: return a | b;
      4'd7: return a & b;
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef CIRNO_CAL_BARREL_SHIFT_EN
    return (op == 4'd0 && b == 32'd0) ? 1 : 1;
`else
    if ((op == 4'd2 || op == 4'd3 || op == 4'd4) && b[4:0] != 5'd0)
      return 1 + (int'(b[4:0]) + STEP - 1) / STEP;
    return 1;
`endif
  endfunction

  // Reference model: a queue of pending results, each due a fixed number of cycles after accept.
  bit   ev, er;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      just_rst = 1'b1;
    end else begin
      ev = (q.size() != 0) && (cyc >= q[0].due);
      er = (q.size() == 0) || (ev && bus.hs_ex4cal_res_rdy);
      chk("res_val", 32'(bus.hs_cal4ex_res_val), 32'(ev));
      chk("req_rdy", 32'(bus.hs_cal4ex_rdy), 32'(er));
      if (ev) begin
        chk("o_res", bus.o_res, q[0].res);
        chk("o_tag", 32'(bus.o_tag), 32'(q[0].tag));
        chk("o_ill", 32'(bus.o_ill), 32'(q[0].ill));
      end
      if (just_rst) begin
        chk("rst_o_res", bus.o_res, 32'd0);
        chk("rst_o_tag", 32'(bus.o_tag), 32'd0);
        chk("rst_o_ill", 32'(bus.o_ill), 32'd0);
        just_rst = 1'b0;
      end
      if (ev && bus.hs_ex4cal_res_rdy) void'(q.pop_front());
      if (bus.hs_ex4cal_val && er) begin
        e.res = model_res(bus.i_op, bus.i_opn1, bus.i_opn2);
        e.tag = bus.i_tag;
        e.ill = (bus.i_op > 4'd9);
        e.due = cyc + model_lat(bus.i_op, bus.i_opn2);
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    bus.hs_ex4cal_val = 1'b1;
    bus.i_op   = op;
    bus.i_opn1 = a;
    bus.i_opn2 = b;
    bus.i_tag  = tag;
  endtask

  // Returns one time unit after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    bit ok;
    ok = 1'b0;
    drive(op, a, b, tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.hs_cal4ex_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("issue_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.hs_ex4cal_val = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    while (!bus.hs_cal4ex_res_val && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("res_timeout", 32'(bus.hs_cal4ex_res_val), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  int  lat;
  int  sent;
  bit  pend;

  initial begin
    bus.hs_ex4cal_val     = 1'b0;
    bus.hs_ex4cal_res_rdy = 1'b1;
    bus.i_op   = 4'd0;
    bus.i_opn1 = 32'd0;
    bus.i_opn2 = 32'd0;
    bus.i_tag  = 4'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_res_val", 32'(bus.hs_cal4ex_res_val), 32'd0);
    chk("reset_rdy", 32'(bus.hs_cal4ex_rdy), 32'd1);
    chk("reset_o_res", bus.o_res, 32'd0);
    @(posedge clk);
    #1;

    // ADD wraps
    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3);
    chk("add_val", 32'(bus.hs_cal4ex_res_val), 32'd1);
    chk("add_res", bus.o_res, 32'h0000_0000);
    chk("add_tag", 32'(bus.o_tag), 32'd3);
    @(posedge clk);
    #1;
    chk("add_val_drop", 32'(bus.hs_cal4ex_res_val), 32'd0);
    chk("add_rdy_back", 32'(bus.hs_cal4ex_rdy), 32'd1);

    // SRA by 31
    issue(4'd4, 32'h8000_0000, 32'h0000_001F, 4'd5);
    wait_res(lat);
`ifdef CIRNO_CAL_BARREL_SHIFT_EN
    chk("sra_latency", 32'(lat), 32'd1);
`else
    chk("sra_latency", 32'(lat), 32'd32);
`endif
    chk("sra_res", bus.o_res, 32'hFFFF_FFFF);

    // compares and zero-amount shift, issued back to back
    issue(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 4'd6);
    wait_res(lat);
    chk("slt_res", bus.o_res, 32'd1);
    issue(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 4'd7);
    wait_res(lat);
    chk("sltu_res", bus.o_res, 32'd0);
    issue(4'd2, 32'h0000_0001, 32'h0000_0000, 4'd8);
    wait_res(lat);
    chk("sll0_latency", 32'(lat), 32'd1);
    chk("sll0_res", bus.o_res, 32'h0000_0001);

    // backpressure, then result handshake and new accept in the same cycle
    @(posedge clk);
    #1 bus.hs_ex4cal_res_rdy = 1'b0;
    issue(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd9);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res", bus.o_res, 32'h0FF0_0FF0);
      chk("bp_tag", 32'(bus.o_tag), 32'd9);
      chk("bp_rdy", 32'(bus.hs_cal4ex_rdy), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.hs_ex4cal_res_rdy = 1'b1;
    issue(4'd6, 32'h1234_0000, 32'h0000_5678, 4'd10);
    chk("or_val", 32'(bus.hs_cal4ex_res_val), 32'd1);
    chk("or_res", bus.o_res, 32'h1234_5678);
    chk("or_tag", 32'(bus.o_tag), 32'd10);

    // illegal opcode, then a legal op clears o_ill
    issue(4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 4'd11);
    wait_res(lat);
    chk("ill_latency", 32'(lat), 32'd1);
    chk("ill_flag", 32'(bus.o_ill), 32'd1);
    chk("ill_res", bus.o_res, 32'd0);
    issue(4'd0, 32'd5, 32'd7, 4'd12);
    wait_res(lat);
    chk("post_ill_flag", 32'(bus.o_ill), 32'd0);
    chk("post_ill_res", bus.o_res, 32'd12);

    // reset during an SLL by 20, in its 10th cycle
    @(posedge clk);
    #1;
    issue(4'd2, 32'h0000_0001, 32'd20, 4'd13);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_res_val", 32'(bus.hs_cal4ex_res_val), 32'd0);
    chk("abort_rdy", 32'(bus.hs_cal4ex_rdy), 32'd1);
    chk("abort_o_res", bus.o_res, 32'd0);
    repeat (30) @(posedge clk);
    #1;

    // mixed traffic with random result backpressure, checked by the model
    sent = 0;
    pend = 1'b0;
    for (int c = 0; c < 4000 && sent < 60; c++) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        drive(4'($urandom_range(0, 13)), $urandom, $urandom, 4'($urandom_range(0, 15)));
        pend = 1'b1;
      end
      bus.hs_ex4cal_res_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pend && bus.hs_cal4ex_rdy) begin
        pend = 1'b0;
        sent++;
      end
      @(posedge clk);
      #1;
      if (!pend) bus.hs_ex4cal_val = 1'b0;
    end
    bus.hs_ex4cal_val     = 1'b0;
    bus.hs_ex4cal_res_rdy = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
